vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Raster timing generator for the 640x480@60 Hz display path. It divides the system clock down to a pixel-rate strobe and runs horizontal and vertical counters. It produces active-low hsync/vsync, a video_on qualifier, and the active-area pixel coordinates row[8:0] and col[9:0]. Those coordinates feed the border/sprite ROM-lookup stages and the colour mux directly downstream.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1); 50 MHz clk gives a 25 MHz pixel rate
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
pix_tick  output  1  one-clk strobe at pixel rate
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
video_on  output  1  high while (h_cnt, v_cnt) is inside the active area
col  output  10  active-area column 0..639; 0 outside the active area
row  output  9  active-area row 0..479; 0 outside the active area
frame_start  output  1  one-clk pulse on the pixel tick that enters (0,0)

Behaviour:
- Decided: one clock (clk); reset is synchronous and active-high (reset). No other clock or reset.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider counter div_cnt, 0..CLK_DIV-1:
  - wraps to 0 after CLK_DIV-1;
  - pix_tick is registered and is 1 in the clk cycle after div_cnt reaches CLK_DIV-1;
  - CLK_DIV=1 gives pix_tick held at 1 after the first post-reset cycle.
- Counters: h_cnt is 10 bits, v_cnt is 10 bits (internal).
  - Both advance only in cycles where the tick condition is true (div_cnt==CLK_DIV-1).
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps, and wraps V_TOTAL-1 -> 0.
- Outputs are registered and computed from the next counter values, so they change in the same cycle as the counters with no skew:
  - video_on = (h<H_ACTIVE) & (v<V_ACTIVE);
  - col = h when h<H_ACTIVE, else 0;
  - row = v[8:0] when v<V_ACTIVE, else 0;
  - hsync = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751);
  - vsync = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491);
  - frame_start = 1 only in the cycle the counters become (0,0).
- Outputs hold their value between ticks.
- Reset state:
  - div_cnt=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1;
  - pix_tick=0, hsync=1, vsync=1, video_on=0, col=0, row=0, frame_start=0.
  - As a result, the first tick after reset wraps to (0,0) and asserts frame_start.
- Reset asserted mid-frame: the next cycle returns to the reset state, with no partial-line output. Reset overrides the tick when both coincide.
- Simultaneous h and v wrap at (799,524): both go to 0 in the same cycle. No intermediate (0,524) state is ever visible.
- Downstream stages sample row/col only when video_on=1; col/row forced to 0 in blanking is required behaviour, not don't-care.
- No arithmetic overflow: counters never exceed TOTAL-1. Comparisons are unsigned and 10 bits wide.

Test Plan:
- Reset for 3 cycles, CLK_DIV=2, then release: hsync=vsync=1 and video_on=0 until the first tick. The first tick arrives 2 clks after release: frame_start=1 for exactly 1 clk, with col=0, row=0, video_on=1.
- Free run one line: col steps 0..639, one step per 2 clks. At h=640, video_on=0 and col=0. hsync is low for exactly 192 clks starting at h=656. The line period is 1600 clks.
- Free run a full frame: the frame_start period is 840000 clks. vsync is low for exactly 3200 clks starting at v=490. row reaches 479 and then reads 0 through v=524.
- Wrap corner: at (799,524) the next tick gives (0,0) with frame_start=1. There is no cycle where row=0 with v_cnt=524 visible as active.
- Assert reset at h=300, v=200 for 1 clk: the next cycle matches the reset state. The following frame_start arrives 2 clks after deassertion.
- CLK_DIV=1 build: pix_tick=1 every cycle after reset, the line period is 800 clks, and hsync is low for exactly 96 clks.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle carried from the timing generator
// to the border/sprite lookup and colour mux stages.
interface vga_timing_gen_if;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] col;
    logic [8:0] row;
    logic       frame_start;
    modport master (output pix_tick, hsync, vsync, video_on, col, row, frame_start);
    modport slave  (input  pix_tick, hsync, vsync, video_on, col, row, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider plus horizontal/vertical raster counters
// producing sync, blanking and active-area coordinates.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA    = 10'(H_ACTIVE);
    localparam logic [9:0] HS0   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VA    = 10'(V_ACTIVE);
    localparam logic [9:0] VS0   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1   = 10'(V_ACTIVE + V_FP + V_SYNC);
    logic [DW-1:0] div_cnt, div_nxt;
    logic [9:0]    h_cnt, v_cnt, h_nxt, v_nxt;
    logic          tick, h_wrap;
    always_comb begin
        tick    = div_cnt == DIV_MAX;
        h_wrap  = tick && h_cnt == H_MAX;
        div_nxt = tick ? '0 : div_cnt + 1'b1;
        h_nxt   = !tick ? h_cnt : h_wrap ? '0 : h_cnt + 10'd1;
        v_nxt   = !h_wrap ? v_cnt : v_cnt == V_MAX ? '0 : v_cnt + 10'd1;
    end
    // Outputs decode the next counter values so they move in lockstep with the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt         <= '0;
            h_cnt           <= H_MAX;
            v_cnt           <= V_MAX;
            vga.pix_tick    <= 1'b0;
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.video_on    <= 1'b0;
            vga.col         <= '0;
            vga.row         <= '0;
            vga.frame_start <= 1'b0;
        end else begin
            div_cnt         <= div_nxt;
            h_cnt           <= h_nxt;
            v_cnt           <= v_nxt;
            vga.pix_tick    <= tick;
            vga.hsync       <= !(h_nxt >= HS0 && h_nxt < HS1);
            vga.vsync       <= !(v_nxt >= VS0 && v_nxt < VS1);
            vga.video_on    <= h_nxt < HA && v_nxt < VA;
            vga.col         <= h_nxt < HA ? h_nxt : '0;
            vga.row         <= v_nxt < VA ? v_nxt[8:0] : '0;
            vga.frame_start <= tick && h_nxt == '0 && v_nxt == '0;
        end
    end
endmodule
